// File: rtl/vault_pkg.sv
// -----------------------------------------------------------------------------
// vault_pkg
// Shared definitions for the vault loader: default register-file geometry and
// the loader FSM state encoding.
// -----------------------------------------------------------------------------
package vault_pkg;

    // Default register-file geometry: four entries of one byte each.
    localparam int DEPTH_DEFAULT = 4;
    localparam int WIDTH_DEFAULT = 8;

    // Loader FSM states.
    //   IDLE   : waiting for start; err/checksum from the last frame are held
    //   LOAD   : accepting upstream bytes and writing them out one per handshake
    //   DRAIN  : the final accepted byte is being written this cycle
    //   VERIFY : reading every entry back and folding it into a running XOR
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        VERIFY = 2'd3
    } vault_state_t;

endpackage

// File: rtl/vault_loader.sv
// -----------------------------------------------------------------------------
// vault_loader
// Loads one frame of DEPTH bytes from a valid/ready upstream into an external
// register file, then reads the whole file back and compares the XOR of the
// readback with the XOR of what was written.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        frame start request, only looked at while idle
//   in_valid     upstream byte valid
//   in_data      upstream byte
//   in_ready     high exactly while loading; a byte moves when valid && ready
//   vault_addr   register-file address for both writes and readback
//   vault_data   register-file write data
//   vault_we     register-file write enable
//   vault_rdata  register-file combinational read data at vault_addr
//   busy         high whenever the loader is not idle
//   done         one-cycle pulse when the readback finishes
//   err          sticky readback mismatch flag, cleared by the next start
//   checksum     XOR of the bytes written in the most recent frame
// -----------------------------------------------------------------------------
module vault_loader
    import vault_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [AW-1:0]    vault_addr,
    output logic [WIDTH-1:0] vault_data,
    output logic             vault_we,
    input  logic [WIDTH-1:0] vault_rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] checksum
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    vault_state_t     state;
    vault_state_t     state_next;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    wr_ptr_next;
    logic [WIDTH-1:0] rd_xor;
    logic [WIDTH-1:0] rd_xor_next;

    logic [AW-1:0]    addr_next;
    logic [WIDTH-1:0] data_next;
    logic             we_next;
    logic             busy_next;
    logic             done_next;
    logic             err_next;
    logic [WIDTH-1:0] checksum_next;

    // The only unregistered output: upstream may hand over a byte exactly
    // while we are in LOAD, so ready follows the state register directly.
    assign in_ready = (state == LOAD);

    // State register. Reset drops straight back to IDLE, abandoning any
    // frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic. Every output except in_ready is
    // computed here one cycle early and then registered, so a handshake in
    // LOAD shows up as a write on the following cycle. Write enable and
    // done default low, so a stall cycle in LOAD writes nothing and done can
    // only ever be a single-cycle pulse. The readback walks vault_addr from
    // 0 to the last entry; the last sample is folded in combinationally so
    // the comparison lands on the same edge that returns to IDLE.
    always_comb begin
        state_next    = state;
        wr_ptr_next   = wr_ptr;
        rd_xor_next   = rd_xor;
        addr_next     = vault_addr;
        data_next     = vault_data;
        we_next       = 1'b0;
        done_next     = 1'b0;
        err_next      = err;
        checksum_next = checksum;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = LOAD;
                    wr_ptr_next   = '0;
                    rd_xor_next   = '0;
                    addr_next     = '0;
                    err_next      = 1'b0;
                    checksum_next = '0;
                end
            end

            LOAD: begin
                if (in_valid) begin
                    we_next       = 1'b1;
                    addr_next     = wr_ptr;
                    data_next     = in_data;
                    wr_ptr_next   = wr_ptr + 1'b1;
                    checksum_next = checksum ^ in_data;
                    if (wr_ptr == LAST_ADDR) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                state_next = VERIFY;
                addr_next  = '0;
            end

            VERIFY: begin
                rd_xor_next = rd_xor ^ vault_rdata;
                addr_next   = vault_addr + 1'b1;
                if (vault_addr == LAST_ADDR) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    err_next   = err | ((rd_xor ^ vault_rdata) != checksum);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // Registered datapath and outputs. Everything clears on reset so the
    // register file sees no write and the next frame starts at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_xor     <= '0;
            vault_addr <= '0;
            vault_data <= '0;
            vault_we   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_xor     <= rd_xor_next;
            vault_addr <= addr_next;
            vault_data <= data_next;
            vault_we   <= we_next;
            busy       <= busy_next;
            done       <= done_next;
            err        <= err_next;
            checksum   <= checksum_next;
        end
    end

endmodule
